// File: rtl/mc_control_seq.sv
// mc_control_seq: multi-cycle MIPS-subset control FSM with memory handshake, retire counter and timeout halt.
// Define MC_JUMP_EN to decode opcode 000010 as a jump; otherwise it halts like any illegal opcode.
module mc_control_seq #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_op,
  output logic [3:0]       state_o,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);
  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC_R = 4'd6;
  localparam logic [3:0] S_RWB    = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_EXEC_I = 4'd9;
  localparam logic [3:0] S_IWB    = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;
  localparam logic [3:0] S_HALT   = 4'd15;
  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  logic [3:0]       state_q, state_d;
  logic [7:0]       timer_q, timer_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             waiting, tmo, retire;
  // Strobes are gated by rst_n so an async reset drops a live request immediately.
  always_comb begin
    mem_req    = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 3'b000;
    halted     = 1'b0;
    state_d    = state_q;
    if (rst_n) begin
      case (state_q)
        S_FETCH: if (run) begin
          mem_req   = 1'b1;
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          if (mem_ack) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = S_DECODE;
          end
        end
        S_DECODE: begin
          alu_src_b = 2'b11;
          state_d   = (opcode == OP_R) ? S_EXEC_R :
                      (opcode == OP_LW || opcode == OP_SW) ? S_MEMADR :
                      (opcode == OP_BEQ) ? S_BRANCH :
                      (opcode == OP_ADDI) ? S_EXEC_I :
`ifdef MC_JUMP_EN
                      (opcode == OP_J) ? S_JUMP :
`endif
                      S_HALT;
        end
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          state_d   = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
        end
        S_MEMRD: begin
          mem_req  = 1'b1;
          mem_read = 1'b1;
          i_or_d   = 1'b1;
          state_d  = mem_ack ? S_MEMWB : S_MEMRD;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          state_d    = S_FETCH;
        end
        S_MEMWR: begin
          mem_req   = 1'b1;
          mem_write = 1'b1;
          i_or_d    = 1'b1;
          state_d   = mem_ack ? S_FETCH : S_MEMWR;
        end
        S_EXEC_R: begin
          alu_src_a = 1'b1;
          alu_op    = 3'b010;
          state_d   = S_RWB;
        end
        S_RWB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
          state_d   = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_a = 1'b1;
          alu_op    = 3'b001;
          pc_src    = 2'b01;
          pc_write  = zero;
          state_d   = S_FETCH;
        end
        S_EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          state_d   = S_IWB;
        end
        S_IWB: begin
          reg_write = 1'b1;
          state_d   = S_FETCH;
        end
`ifdef MC_JUMP_EN
        S_JUMP: begin
          pc_write = 1'b1;
          pc_src   = 2'b10;
          state_d  = S_FETCH;
        end
`endif
        S_HALT: halted = 1'b1;
        default: state_d = S_HALT;
      endcase
    end
    waiting   = mem_req & ~mem_ack;
    tmo       = waiting && (timer_q == 8'(TIMEOUT - 1));
    timer_d   = (waiting && !tmo) ? timer_q + 8'd1 : 8'd0;
    state_d   = tmo ? S_HALT : state_d;
    retire    = (state_q inside {S_MEMWB, S_RWB, S_IWB, S_BRANCH, S_JUMP}) ||
                (state_q == S_MEMWR && mem_ack);
    retired_d = retired_q + CNT_W'(retire);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      timer_q   <= 8'd0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      retired_q <= retired_d;
    end
  end
  assign state_o = state_q;
  assign retired = retired_q;
endmodule

// File: tb/tb_mc_control_seq.sv
// tb_mc_control_seq: directed programs against a table-driven reference model, checked every cycle.
module tb_mc_control_seq;
  localparam int TIMEOUT = 15;
  typedef struct {
    logic [5:0] op;
    logic       z;
    int         lat;
  } instr_t;
  logic        clk, rst_n, run, zero, mem_ack;
  logic [5:0]  opcode;
  logic        mem_req, i_or_d, mem_read, mem_write, ir_write, pc_write;
  logic [1:0]  pc_src, alu_src_b;
  logic        reg_dst, reg_write, mem_to_reg, alu_src_a, halted;
  logic [2:0]  alu_op;
  logic [3:0]  state_o;
  logic [31:0] retired;
  logic [17:0] dut_ctl;
  int          tests = 0, fails = 0;
  mc_control_seq #(.CNT_W(32), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .zero(zero), .mem_ack(mem_ack),
    .mem_req(mem_req), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .reg_dst(reg_dst),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .state_o(state_o), .halted(halted),
    .retired(retired)
  );
  assign dut_ctl = {mem_req, i_or_d, mem_read, mem_write, ir_write, pc_write, pc_src,
                    reg_dst, reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op, halted};
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // Expected strobes as one literal per state:
  // {req,iod,mrd,mwr,irw,pcw} {pc_src} {rdst,rwr,m2r,srca} {srcb} {aluop} {halt}
  function automatic logic [17:0] exp_ctl(input int st, input logic rn, input logic r,
                                          input logic ack, input logic z);
    if (!rn) return '0;
    case (st)
      0:  return !r ? 18'd0 : ack ? {6'b101011, 2'b00, 4'b0000, 2'b01, 3'b000, 1'b0}
                                  : {6'b101000, 2'b00, 4'b0000, 2'b01, 3'b000, 1'b0};
      1:  return {6'b000000, 2'b00, 4'b0000, 2'b11, 3'b000, 1'b0};
      2:  return {6'b000000, 2'b00, 4'b0001, 2'b10, 3'b000, 1'b0};
      3:  return {6'b111000, 2'b00, 4'b0000, 2'b00, 3'b000, 1'b0};
      4:  return {6'b000000, 2'b00, 4'b0110, 2'b00, 3'b000, 1'b0};
      5:  return {6'b110100, 2'b00, 4'b0000, 2'b00, 3'b000, 1'b0};
      6:  return {6'b000000, 2'b00, 4'b0001, 2'b00, 3'b010, 1'b0};
      7:  return {6'b000000, 2'b00, 4'b1100, 2'b00, 3'b000, 1'b0};
      8:  return {5'b00000, z, 2'b01, 4'b0001, 2'b00, 3'b001, 1'b0};
      9:  return {6'b000000, 2'b00, 4'b0001, 2'b10, 3'b000, 1'b0};
      10: return {6'b000000, 2'b00, 4'b0100, 2'b00, 3'b000, 1'b0};
      11: return {6'b000001, 2'b10, 4'b0000, 2'b00, 3'b000, 1'b0};
      default: return {17'd0, 1'b1};
    endcase
  endfunction
  function automatic int next_state(input int st, input logic r, input logic ack,
                                    input logic [5:0] op);
    case (st)
      0: return (r && ack) ? 1 : 0;
      1: return (op == 6'h00) ? 6 : (op == 6'h23 || op == 6'h2b) ? 2 : (op == 6'h04) ? 8 :
`ifdef MC_JUMP_EN
                (op == 6'h02) ? 11 :
`endif
                (op == 6'h08) ? 9 : 15;
      2: return (op == 6'h23) ? 3 : 5;
      3: return ack ? 4 : 3;
      5: return ack ? 0 : 5;
      6: return 7;
      9: return 10;
      4, 7, 8, 10, 11: return 0;
      default: return 15;
    endcase
  endfunction
  int          m_state, m_timer;
  logic [31:0] m_ret;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state <= 0;
      m_timer <= 0;
      m_ret   <= '0;
    end else begin
      automatic logic [17:0] ctl = exp_ctl(m_state, 1'b1, run, mem_ack, zero);
      automatic int wt = (ctl[17] && !mem_ack) ? m_timer + 1 : 0;
      automatic bit ret = (m_state inside {4, 7, 8, 10, 11}) || (m_state == 5 && mem_ack);
      m_state <= (wt == TIMEOUT) ? 15 : next_state(m_state, run, mem_ack, opcode);
      m_timer <= (wt == TIMEOUT) ? 0 : wt;
      m_ret   <= m_ret + (ret ? 32'd1 : 32'd0);
    end
  end
  always @(negedge clk) begin
    chk("ctl", {14'd0, dut_ctl}, {14'd0, exp_ctl(m_state, rst_n, run, mem_ack, zero)});
    chk("state", {28'd0, state_o}, rst_n ? m_state : 0);
    chk("retired", retired, m_ret);
  end
  // Observation counters used by the literal checks.
  logic [3:0] trace[$];
  int br_taken, jmp_cnt, rd_cnt, wr_cur, wr_last;
  always @(negedge clk) begin
    if (!rst_n) begin
      trace.delete();
      br_taken <= 0;
      jmp_cnt  <= 0;
      rd_cnt   <= 0;
      wr_cur   <= 0;
      wr_last  <= 0;
    end else begin
      if (trace.size() == 0 || trace[trace.size()-1] != state_o) trace.push_back(state_o);
      if (state_o == 4'd8 && pc_write) br_taken <= br_taken + 1;
      if (pc_src == 2'b10) jmp_cnt <= jmp_cnt + 1;
      if (state_o == 4'd3) rd_cnt <= rd_cnt + 1;
      wr_cur <= (state_o == 4'd5) ? wr_cur + 1 : 0;
      if (state_o != 4'd5 && wr_cur != 0) wr_last <= wr_cur;
    end
  end
  function automatic logic [31:0] trace_val(input int n);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v = (v << 4) | ((i < trace.size()) ? {28'd0, trace[i]} : 32'hE);
    return v;
  endfunction
  // Memory responder: acks the n-th consecutive request cycle (fetch n=3, data per instruction, 0 = never).
  instr_t prog[$];
  instr_t cur;
  int     pi, cnt;
  initial begin
    mem_ack = 1'b0;
    opcode  = 6'h00;
    zero    = 1'b0;
    cur     = '{6'h3f, 1'b0, 0};
    pi      = 0;
    cnt     = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        cnt     = 0;
        pi      = 0;
        mem_ack = 1'b0;
      end else begin
        cnt     = mem_req ? cnt + 1 : 0;
        mem_ack = mem_req && (cnt == (i_or_d ? cur.lat : 3));
        if (mem_ack) begin
          cnt = 0;
          if (!i_or_d) begin
            if (pi < prog.size()) cur = prog[pi];
            else cur = '{6'h3f, 1'b0, 0};
            pi++;
            opcode = cur.op;
            zero   = cur.z;
          end
        end
      end
    end
  end
  task automatic begin_run();
    rst_n = 1'b0;
    run   = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask
  task automatic wait_halt(input int n);
    for (int i = 0; i < n && !halted; i++) @(posedge clk);
    @(negedge clk);
    #1;
    chk("halted", {31'd0, halted}, 32'd1);
  endtask
  initial begin
    rst_n = 1'b0;
    run   = 1'b0;
    prog = '{'{6'h00, 1'b0, 0}, '{6'h23, 1'b0, 3}, '{6'h04, 1'b1, 0}, '{6'h04, 1'b0, 0},
             '{6'h08, 1'b0, 0}, '{6'h2b, 1'b0, 15}, '{6'h2b, 1'b0, 0}};
    begin_run();
    @(negedge clk);
    chk("A_reset_retired", retired, 32'd0);
    chk("A_idle_req", {31'd0, mem_req}, 32'd0);
    repeat (3) @(posedge clk);
    #2 run = 1'b1;
    for (int i = 0; i < 100 && state_o != 4'd6; i++) begin
      @(posedge clk);
      #2;
    end
    run = 1'b0;
    repeat (5) @(posedge clk);
    #2 run = 1'b1;
    wait_halt(800);
    chk("A_retired", retired, 32'd6);
    chk("A_halt_req", {31'd0, mem_req}, 32'd0);
    chk("A_trace", trace_val(5), 32'h01670);
    chk("A_br_taken", br_taken, 32'd1);
    chk("A_rd_cycles", rd_cnt, 32'd3);
    chk("A_wr_timeout", wr_last, 32'd15);
    prog = '{'{6'h3f, 1'b0, 0}};
    begin_run();
    run = 1'b1;
    wait_halt(100);
    chk("B_retired", retired, 32'd0);
    chk("B_trace", trace_val(3), 32'h01F);
    prog = '{'{6'h02, 1'b0, 0}, '{6'h00, 1'b0, 0}};
    begin_run();
    run = 1'b1;
    wait_halt(200);
`ifdef MC_JUMP_EN
    chk("C_retired", retired, 32'd2);
    chk("C_jump", jmp_cnt, 32'd1);
    chk("C_trace", trace_val(5), 32'h01B01);
`else
    chk("C_retired", retired, 32'd0);
    chk("C_jump", jmp_cnt, 32'd0);
    chk("C_trace", trace_val(3), 32'h01F);
`endif
    prog = '{'{6'h00, 1'b0, 0}, '{6'h23, 1'b0, 0}};
    begin_run();
    run = 1'b1;
    for (int i = 0; i < 100 && state_o != 4'd3; i++) begin
      @(posedge clk);
      #2;
    end
    @(posedge clk);
    #3;
    chk("D_pre_retired", retired, 32'd1);
    chk("D_pre_req", {31'd0, mem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("D_rst_ctl", {14'd0, dut_ctl}, 32'd0);
    chk("D_rst_retired", retired, 32'd0);
    chk("D_rst_state", {28'd0, state_o}, 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    chk("D_rel_req", {31'd0, mem_req}, 32'd1);
    chk("D_rel_state", {28'd0, state_o}, 32'd0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mc_control_seq.md
Name: mc_control_seq

Overview:
- Multi-cycle sequencer for the MIPS-subset datapath: PC, instruction/data memory, register bank, ALU controller, ALU.
- Replaces the single-cycle combinational control unit with an FSM that issues per-state control strobes.
- Waits on a memory acknowledge handshake, counts retired instructions, and halts on an illegal opcode or a memory timeout.

Parameters:
- CNT_W, 32, width of retired-instruction counter
- TIMEOUT, 15, max wait cycles for mem_ack before halt (1..255)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- run  in  1  fetch enable; low holds the FSM in FETCH with no request
- opcode  in  6  IR[31:26], valid from DECODE onward
- zero  in  1  ALU ZF
- mem_ack  in  1  memory access complete (1-cycle pulse)
- mem_req  out  1  memory access request
- i_or_d  out  1  address source: 0 = PC, 1 = ALUOut
- mem_read  out  1  read strobe
- mem_write  out  1  write strobe
- ir_write  out  1  load IR
- pc_write  out  1  load PC
- pc_src  out  2  PC source: 00 = ALU (PC+4), 01 = ALUOut (branch target), 10 = jump target
- reg_dst  out  1  write address: 1 = rd, 0 = rt
- reg_write  out  1  register bank write enable
- mem_to_reg  out  1  write-back data: 1 = MDR, 0 = ALUOut
- alu_src_a  out  1  ALU A: 0 = PC, 1 = rs data
- alu_src_b  out  2  ALU B: 00 = rt, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
- alu_op  out  3  code to ALU controller: 000 ADD, 001 SUB, 010 use funct
- state_o  out  4  current state encoding
- halted  out  1  FSM in HALT
- retired  out  CNT_W  retired-instruction count

Behaviour:
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC_R 6, RWB 7, BRANCH 8, EXEC_I 9, IWB 10, JUMP 11, HALT 15.
- Reset: while rst_n=0, state = FETCH, retired = 0, wait timer = 0, every output = 0. The first FETCH request is issued in the first cycle after release if run=1.
- Any output not listed for a state is 0.
- FETCH:
  - run=0: no request, timer cleared, stay in FETCH.
  - run=1: mem_req=1, mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=000.
  - On mem_ack, same cycle (Mealy): ir_write=1, pc_write=1, pc_src=00; next state DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=000. Next state by opcode:
  - 000000 -> EXEC_R
  - 100011 or 101011 -> MEMADR
  - 000100 -> BRANCH
  - 001000 -> EXEC_I
  - 000010 -> JUMP (only with macro, see below)
  - anything else -> HALT
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=000. Next MEMRD if opcode=100011, else MEMWR.
- MEMRD: mem_req=1, mem_read=1, i_or_d=1. Stay until mem_ack, then MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1 -> FETCH.
- MEMWR: mem_req=1, mem_write=1, i_or_d=1. Stay until mem_ack, then FETCH.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=010 -> RWB.
- RWB: reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=001, pc_src=01, pc_write=zero (combinational) -> FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=000 -> IWB.
- IWB: reg_write=1, reg_dst=0, mem_to_reg=0 -> FETCH.
- HALT: halted=1, all strobes 0. Exit only via rst_n.
- Retire: retired increments by 1 on leaving MEMWB, RWB, IWB, BRANCH, JUMP, and on MEMWR with mem_ack. It wraps modulo 2^CNT_W. HALT does not retire.
- Timeout:
  - The wait timer counts cycles with mem_req=1 and mem_ack=0, and is cleared on ack or state change.
  - When the timer reaches TIMEOUT, next state is HALT.
  - A mem_ack arriving in the same cycle the timer reaches TIMEOUT wins: normal transition.
- run falling mid-instruction has no effect until the FSM returns to FETCH. A request already in flight in FETCH is dropped only if run=0 before ack; memory must tolerate a withdrawn request.
- Asynchronous reset mid-access immediately deasserts mem_req and all strobes.
- mem_ack outside the request states is ignored.

Optional Feature:
- MC_JUMP_EN defined:
  - Opcode 000010 goes to JUMP.
  - JUMP: pc_write=1, pc_src=10 -> FETCH; the instruction retires.
- MC_JUMP_EN undefined: opcode 000010 goes to HALT, and pc_src never takes value 10.

Test Plan:
- Reset, run=1, ack 2 cycles after each req; R-type add (opcode 0) -> states 0,1,6,7,0; alu_op=010 in EXEC_R; reg_write=1 with reg_dst=1 in RWB; retired=1.
- lw (100011) with ack on 3rd wait cycle -> MEMRD held 3 cycles; MEMWB shows mem_to_reg=1, reg_dst=0; retired increments once.
- beq with zero=1, then beq with zero=0 -> pc_write=1 with pc_src=01 for the first; pc_write=0 for the second; retired=2.
- sw with mem_ack never asserted, TIMEOUT=15 -> HALT entered after 15 wait cycles; halted=1, mem_req=0, retired unchanged.
- Opcode 111111 -> HALT from DECODE. Opcode 000010 -> JUMP with macro, HALT without.
- rst_n pulsed low mid-MEMRD -> all outputs 0 asynchronously, retired=0; after release, FETCH with mem_req=1 (run=1).
